// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide controller.
package muldiv_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ITER   = WIDTH;
    localparam int unsigned WORK_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W  = 6;

    // Operation encodings on op_i
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MUL_RUN = 2'd1;
    localparam logic [1:0] ST_DIV_RUN = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // LO value returned for a divide by zero
    localparam logic [WIDTH-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Working register layout: {carry, hi[WIDTH-1:0], lo[WIDTH-1:0]}.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [WORK_W-1:0] work_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              div_i,
    output logic [WORK_W-1:0] work_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] part;
    logic [WIDTH-1:0] diff;

    // Multiply consumes lo LSB-first; divide shifts the dividend into the remainder MSB-first
    always_comb begin
        acc    = work_i[2*WIDTH-1:WIDTH];
        lo     = work_i[WIDTH-1:0];
        sum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd_i} : (WIDTH+1)'(0));
        part   = {work_i[WORK_W-1:WIDTH], lo[WIDTH-1]};
        diff   = part[WIDTH-1:0] - opnd_i;
        work_o = {1'b0, sum, lo[WIDTH-1:1]};
        if (div_i) begin
            if (part >= {2'b00, opnd_i}) begin
                work_o = {1'b0, diff, lo[WIDTH-2:0], 1'b1};
            end else begin
                work_o = {1'b0, part[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller with pipeline stall and ready pulse.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_i,
    input  logic [1:0]    op_i,
    input  logic [31:0]   opdata1_i,
    input  logic [31:0]   opdata2_i,
    input  logic          annul_i,
    output logic [63:0]   result_o,
    output logic          ready_o,
    output logic          busy_o,
    output logic          stall_o
);

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WORK_W-1:0]  work_q,   work_d;
    logic [WORK_W-1:0]  work_step;
    logic [WIDTH-1:0]   opnd_q,   opnd_d;
    logic               div_q,    div_d;
    logic               sgn_q,    sgn_d;
    logic               s1_q,     s1_d;
    logic               s2_q,     s2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q,  ready_d;
    logic               busy_q,   busy_d;

    logic               is_div;
    logic               is_sgn;
    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] fixed;

    muldiv_step u_step (
        .work_i (work_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .work_o (work_step)
    );

    // Decode the request and form operand magnitudes
    always_comb begin
        is_div = (op_i == MD_DIV) || (op_i == MD_DIVU);
        is_sgn = (op_i == MD_MULT) || (op_i == MD_DIV);
        neg1   = is_sgn & opdata1_i[WIDTH-1];
        neg2   = is_sgn & opdata2_i[WIDTH-1];
        abs1   = neg1 ? WIDTH'(-opdata1_i) : opdata1_i;
        abs2   = neg2 ? WIDTH'(-opdata2_i) : opdata2_i;
    end

    // Sign-correct the final iteration's output for loading into result_o
    always_comb begin
        prod    = work_step[2*WIDTH-1:0];
        quo     = work_step[WIDTH-1:0];
        rem     = work_step[2*WIDTH-1:WIDTH];
        quo_fix = (sgn_q & (s1_q ^ s2_q)) ? WIDTH'(-quo) : quo;
        rem_fix = (sgn_q & s1_q) ? WIDTH'(-rem) : rem;
        if (div_q) begin
            fixed = {rem_fix, quo_fix};
        end else begin
            fixed = (sgn_q & (s1_q ^ s2_q)) ? (2*WIDTH)'(-prod) : prod;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        sgn_d    = sgn_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    cnt_d = '0;
                    div_d = is_div;
                    sgn_d = is_sgn;
                    s1_d  = neg1;
                    s2_d  = neg2;
                    if (is_div) begin
                        if (opdata2_i == '0) begin
                            state_d  = ST_DONE;
                            ready_d  = 1'b1;
                            result_d = {opdata1_i, DIV_ZERO_LO};
                        end else begin
                            state_d = ST_DIV_RUN;
                            work_d  = {1'b0, WIDTH'(0), abs1};
                            opnd_d  = abs2;
                        end
                    end else begin
                        state_d = ST_MUL_RUN;
                        work_d  = {1'b0, WIDTH'(0), abs2};
                        opnd_d  = abs1;
                    end
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        ready_d  = 1'b1;
                        result_d = fixed;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
            sgn_q    <= sgn_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign stall_o  = ((state_q == ST_IDLE) & start_i & ~annul_i)
                    | (state_q == ST_MUL_RUN)
                    | (state_q == ST_DIV_RUN);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic, latency, stall, annul and reset.
module tb_muldiv_ctrl;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        stall_o;

    int n_total = 0;
    int n_bad   = 0;

    muldiv_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at the current negedge; return result, edges to ready, stall cycles
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output logic [63:0] res, output int lat,
                         output int stalls, output bit got);
        start_i   = 1'b1;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        lat = 0; stalls = 0; got = 0; res = '0;
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if (stall_o) stalls++;
            @(posedge clk);
            lat++;
            #1;
            if (!hold) start_i = 1'b0;
            @(negedge clk);
            if (ready_o) begin
                got = 1;
                res = result_o;
            end
        end
        start_i = 1'b0;
    endtask

    // Run an op and check result, latency, stall length, DONE stall and pulse width
    task automatic run_chk(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                           input bit hold);
        logic [63:0] res;
        int lat, stalls;
        bit got;
        do_op(op, a, b, hold, res, lat, stalls, got);
        chk({tag, "_seen"}, 64'(got), 64'd1);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_lat));
        chk({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(ready_o), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; start_i = 1'b0; op_i = 2'b00;
        opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // start_i held through the run must not launch a second operation
        run_chk("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1);
        run_chk("mult_m1x7", 2'b00, 32'hFFFF_FFFF, 32'd7, 64'hFFFF_FFFF_FFFF_FFF9, 33, 0);
        run_chk("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 33, 0);
        run_chk("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_chk("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 0);
        run_chk("divu_100_7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0);
        run_chk("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0);
        run_chk("divu_by0", 2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 0);

        // Annul a MULTU after 10 iterations; result must stay at the divide-by-zero value
        start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd3; opdata2_i = 32'd4;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("annul_busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'h0000_0005_FFFF_FFFF);
        annul_i = 1'b0;
        run_chk("divu_9_2", 2'b11, 32'd9, 32'd2, 64'h0000_0001_0000_0004, 33, 0);

        // Annul in IDLE blocks acceptance
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01;
        #1;
        chk("annul_idle_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("annul_idle_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // Reset in the middle of a multiply
        start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd3; opdata2_i = 32'd4;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        run_chk("post_rst_multu", 2'b01, 32'd3, 32'd4, 64'd12, 33, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
